// File: rtl/mode_accumulator.sv
// rtl/mode_accumulator.sv - two-stage pipelined add/sub/load/clear accumulator with saturation and flags
//
// Purpose: stage 1 captures an operation, and stage 2 applies it to the
// accumulator S one edge later. There is no stall, so a new operation can be
// accepted every cycle.
//
// Ports:
//   Clock       rising-edge clock
//   Reset       asynchronous, active-low reset
//   in_valid    qualifies A / op / sat_en this cycle
//   A           N-bit operand
//   op          00 add, 01 subtract, 10 load, 11 clear
//   sat_en      signed saturation for add/subtract
//   clr_flags   clears ovf_sticky and op_count (acts on the current edge)
//   out_valid   one-cycle pulse per executed operation
//   S           accumulator value
//   carry       carry-out of add / no-borrow of subtract
//   overflow    signed overflow of the last add/subtract, before saturation
//   ovf_sticky  any overflow since the last flag clear
//   op_count    executed operations, modulo 2^CNT_W
module mode_accumulator #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             in_valid,
    input  logic [N-1:0]     A,
    input  logic [1:0]       op,
    input  logic             sat_en,
    input  logic             clr_flags,
    output logic             out_valid,
    output logic [N-1:0]     S,
    output logic             carry,
    output logic             overflow,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam int W1 = N + 1;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MAX_NEG = {1'b1, {(N-1){1'b0}}};

    // Stage-1 capture registers
    logic         v1;
    logic [N-1:0] a1;
    logic [1:0]   op1;
    logic         sat1;

    // Stage-2 next-state values
    logic [N:0]   add_full;
    logic [N:0]   sub_full;
    logic [N-1:0] sat_val;
    logic [N-1:0] s_nxt;
    logic         c_nxt;
    logic         o_nxt;
    logic         ovf_event;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            v1   <= 1'b0;
            a1   <= '0;
            op1  <= '0;
            sat1 <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                a1   <= A;
                op1  <= op;
                sat1 <= sat_en;
            end
        end
    end

    always_comb begin
        add_full = {1'b0, S} + {1'b0, a1};
        sub_full = {1'b0, S} + {1'b0, ~a1} + W1'(1);
        // On overflow the sign of S tells which rail the true result ran past.
        sat_val  = S[N-1] ? MAX_NEG : MAX_POS;
        s_nxt    = S;
        c_nxt    = carry;
        o_nxt    = overflow;
        case (op1)
            OP_ADD: begin
                c_nxt = add_full[N];
                o_nxt = (S[N-1] == a1[N-1]) && (add_full[N-1] != S[N-1]);
                s_nxt = (sat1 && o_nxt) ? sat_val : add_full[N-1:0];
            end
            OP_SUB: begin
                c_nxt = sub_full[N];
                o_nxt = (S[N-1] != a1[N-1]) && (sub_full[N-1] != S[N-1]);
                s_nxt = (sat1 && o_nxt) ? sat_val : sub_full[N-1:0];
            end
            OP_LOAD: begin
                c_nxt = 1'b0;
                o_nxt = 1'b0;
                s_nxt = a1;
            end
            OP_CLEAR: begin
                c_nxt = 1'b0;
                o_nxt = 1'b0;
                s_nxt = '0;
            end
            default: begin
                c_nxt = carry;
                o_nxt = overflow;
                s_nxt = S;
            end
        endcase
        ovf_event = v1 && o_nxt;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            S         <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                S        <= s_nxt;
                carry    <= c_nxt;
                overflow <= o_nxt;
            end
        end
    end

    // A new overflow on the same edge as a clear takes priority.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ovf_sticky <= 1'b0;
        end else if (ovf_event) begin
            ovf_sticky <= 1'b1;
        end else if (clr_flags) begin
            ovf_sticky <= 1'b0;
        end
    end

    // A clear that coincides with an executing operation still counts that operation.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            op_count <= '0;
        end else if (clr_flags) begin
            op_count <= v1 ? CNT_W'(1) : '0;
        end else if (v1) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
